data_mem_responder: RTL

- Responder side of the Mem_r / Mem_w interface driven by the main decoder. Services word loads and stores against an internal data array with a fixed multi-cycle latency.
- Holds the pipeline with Stall until the access completes.
- Flags misaligned or out-of-range addresses instead of accessing memory.
- Sits between the ALU result (address), the register-file read port (store data) and the Mem_to_reg write-back mux.

---
 rtl/data_mem_responder_pkg.sv | 30 +++
 rtl/data_mem_responder_array.sv | 41 ++++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e   : responder FSM states (IDLE / BUSY / DONE), 2-bit encoding
//   WORD_OFF  : byte-to-word shift for 32-bit words
//   clog2()   : index/counter width helper (never returns less than 1)
//   OP_LW/SW  : main-decoder opcodes that drive Mem_r / Mem_w
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WORD_OFF = 2;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  // Clamped to 1 so a DEPTH or counter range of 1 still yields a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Synchronous single-port word array for the data-memory responder.
//   clk, rst : clock, async active-high reset (read register only)
//   we, re   : write / read enable, sampled on the rising edge
//   idx      : word index
//   wdata    : store data
//   rdata    : registered read data, holds until the next read
module data_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset; contents are undefined until written.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the Mem_r / Mem_w load-store interface.
//   clk, rst   : clock, async active-high reset
//   Mem_r/w    : load / store request levels, held while Stall = 1
//   Addr       : byte address (must be word aligned and inside the array)
//   Write_data : store data
//   Read_data  : registered load result, holds until the next completed load
//   Stall      : pipeline hold (combinational in the acceptance cycle)
//   Done       : one-cycle completion pulse
//   Addr_err   : one-cycle pulse, cycle after a rejected request
//
// state | meaning
// IDLE  | waiting; a valid request is latched and accepted this cycle
// BUSY  | counting latency; array access commits when counter == LATENCY
// DONE  | Done pulse, Read_data valid, pipeline released
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Mem_r,
  input  logic              Mem_w,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] Write_data,
  output logic [DATA_W-1:0] Read_data,
  output logic              Stall,
  output logic              Done,
  output logic              Addr_err
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int CNT_W = clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              op_w_d, op_w_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              addr_err_d, addr_err_q;

  logic req, aligned, in_range, valid, commit, stall, done;

  assign req      = Mem_r | Mem_w;
  assign aligned  = (Addr[WORD_OFF-1:0] == '0);
  // Full-width compare so high address bits can never alias into the array.
  assign in_range = ({{WORD_OFF{1'b0}}, Addr[31:WORD_OFF]} < 32'(DEPTH));
  assign valid    = req & aligned & in_range & ~(Mem_r & Mem_w);
  assign commit   = (state_q == ST_BUSY) && (cnt_q == LAT_C);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_w_d     = op_w_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    addr_err_d = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (valid) begin
            op_w_d  = Mem_w;
            idx_d   = Addr[WORD_OFF +: IDX_W];
            wdata_d = Write_data;
            cnt_d   = CNT_W'(1);
            stall   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (cnt_q == LAT_C) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Any request still visible here belongs to the finishing access.
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_w_q     <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_w_q     <= op_w_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (commit & op_w_q),
    .re    (commit & ~op_w_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (Read_data)
  );

  // Acceptance stall is combinational on the request, so mask it while in reset.
  assign Stall    = stall & ~rst;
  assign Done     = done;
  assign Addr_err = addr_err_q;

endmodule
